// File: rtl/br_resolve_queue.sv
// Branch resolve queue: FIFO of predicted branches, resolved in order, emitting predictor updates and mispredict redirects.
// Optional statistics counters enabled by defining BRQ_STATS_EN.
module br_resolve_queue #(
   parameter int unsigned s_idx = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [31:0]      push_pc,
   input  logic             push_take,
   input  logic [31:0]      push_target,
   input  logic             resolve,
   input  logic             resolve_br_en,
   input  logic [31:0]      resolve_target,
   output logic             full,
   output logic             empty,
   output logic [s_idx:0]   count,
   output logic             update,
   output logic             upd_br_en,
   output logic [31:0]      upd_waddr,
   output logic             redirect,
   output logic [31:0]      redirect_pc
`ifdef BRQ_STATS_EN
   ,
   output logic [31:0]      stat_resolved,
   output logic [31:0]      stat_mispred
`endif
);

   localparam int unsigned DEPTH = 2 ** s_idx;
   localparam logic [s_idx:0] FULL_CNT = {1'b1, {s_idx{1'b0}}};

   logic [31:0]      pc_mem   [DEPTH];
   logic             take_mem [DEPTH];
   logic [31:0]      tgt_mem  [DEPTH];

   logic [s_idx-1:0] head_q, head_d, tail_q, tail_d;
   logic [s_idx:0]   count_q, count_d;
   logic             update_q, update_d;
   logic             upd_br_en_q, upd_br_en_d;
   logic [31:0]      upd_waddr_q, upd_waddr_d;
   logic             redirect_q, redirect_d;
   logic [31:0]      redirect_pc_q, redirect_pc_d;

   logic             res_acc, push_acc, mispred;
   logic [31:0]      head_pc, head_tgt;
   logic             head_take;

   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);
   assign count = count_q;

   assign head_pc   = pc_mem[head_q];
   assign head_take = take_mem[head_q];
   assign head_tgt  = tgt_mem[head_q];

   assign res_acc = resolve & ~empty;
   assign mispred = res_acc & ((head_take != resolve_br_en) |
                               (head_take & resolve_br_en & (head_tgt != resolve_target)));
   // A full queue may still take a push when the oldest entry retires cleanly this cycle.
   assign push_acc = push & ~mispred & (~full | res_acc);

   always_comb begin
      head_d        = head_q;
      tail_d        = tail_q;
      count_d       = count_q;
      update_d      = 1'b0;
      upd_br_en_d   = upd_br_en_q;
      upd_waddr_d   = upd_waddr_q;
      redirect_d    = 1'b0;
      redirect_pc_d = redirect_pc_q;
      if (res_acc) begin
         update_d    = 1'b1;
         upd_br_en_d = resolve_br_en;
         upd_waddr_d = head_pc;
      end
      if (mispred) begin
         redirect_d    = 1'b1;
         redirect_pc_d = resolve_br_en ? resolve_target : head_pc + 32'd4;
         head_d        = tail_q;
         count_d       = '0;
      end else begin
         if (res_acc)
            head_d = head_q + s_idx'(1);
         if (push_acc)
            tail_d = tail_q + s_idx'(1);
         if (push_acc && !res_acc)
            count_d = count_q + (s_idx+1)'(1);
         else if (!push_acc && res_acc)
            count_d = count_q - (s_idx+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         update_q      <= 1'b0;
         upd_br_en_q   <= 1'b0;
         upd_waddr_q   <= '0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
      end else begin
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
         update_q      <= update_d;
         upd_br_en_q   <= upd_br_en_d;
         upd_waddr_q   <= upd_waddr_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push_acc) begin
         pc_mem[tail_q]   <= push_pc;
         take_mem[tail_q] <= push_take;
         tgt_mem[tail_q]  <= push_target;
      end
   end

   assign update      = update_q;
   assign upd_br_en   = upd_br_en_q;
   assign upd_waddr   = upd_waddr_q;
   assign redirect    = redirect_q;
   assign redirect_pc = redirect_pc_q;

`ifdef BRQ_STATS_EN
   logic [31:0] stat_resolved_q, stat_resolved_d;
   logic [31:0] stat_mispred_q, stat_mispred_d;

   // Counted off the registered strobes, so they advance one cycle after the resolve.
   always_comb begin
      stat_resolved_d = stat_resolved_q + {31'b0, update_q};
      stat_mispred_d  = stat_mispred_q + {31'b0, redirect_q};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_resolved_q <= '0;
         stat_mispred_q  <= '0;
      end else begin
         stat_resolved_q <= stat_resolved_d;
         stat_mispred_q  <= stat_mispred_d;
      end
   end

   assign stat_resolved = stat_resolved_q;
   assign stat_mispred  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_br_resolve_queue.sv
// Randomized and directed bench for br_resolve_queue against a queue-based reference model.
// Define BRQ_STATS_EN to also exercise the statistics counters.
module tb_br_resolve_queue;

   localparam int unsigned SIDX  = 3;
   localparam int unsigned DEPTH = 8;

   typedef struct {
      logic [31:0] pc;
      logic        take;
      logic [31:0] tgt;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst, push, push_take, resolve, resolve_br_en;
   logic [31:0] push_pc, push_target, resolve_target;
   logic        full, empty, update, upd_br_en, redirect;
   logic [SIDX:0] count;
   logic [31:0] upd_waddr, redirect_pc;
`ifdef BRQ_STATS_EN
   logic [31:0] stat_resolved, stat_mispred;
`endif

   int vectors = 0;
   int miscompares = 0;

   ent_t        mq[$];
   logic        exp_update, exp_upd_br_en, exp_redirect;
   logic [31:0] exp_upd_waddr, exp_redirect_pc;
   logic [31:0] exp_res, exp_mis;

   br_resolve_queue #(.s_idx(SIDX)) dut (
      .clk(clk), .rst(rst), .push(push), .push_pc(push_pc), .push_take(push_take),
      .push_target(push_target), .resolve(resolve), .resolve_br_en(resolve_br_en),
      .resolve_target(resolve_target), .full(full), .empty(empty), .count(count),
      .update(update), .upd_br_en(upd_br_en), .upd_waddr(upd_waddr),
      .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef BRQ_STATS_EN
      , .stat_resolved(stat_resolved), .stat_mispred(stat_mispred)
`endif
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs, advance the model across the edge, return 1 time unit after it.
   task automatic step(input logic r, input logic p, input logic [31:0] ppc, input logic ptk,
                       input logic [31:0] ptg, input logic rs, input logic rben, input logic [31:0] rtg);
      ent_t e;
      bit   was_full, racc, mis;
      rst = r; push = p; push_pc = ppc; push_take = ptk; push_target = ptg;
      resolve = rs; resolve_br_en = rben; resolve_target = rtg;
      @(posedge clk);
      if (r) begin
         mq.delete();
         exp_update = 0; exp_upd_br_en = 0; exp_upd_waddr = 0;
         exp_redirect = 0; exp_redirect_pc = 0; exp_res = 0; exp_mis = 0;
      end else begin
         if (exp_update)   exp_res = exp_res + 1;
         if (exp_redirect) exp_mis = exp_mis + 1;
         was_full = (mq.size() == DEPTH);
         racc = rs && (mq.size() > 0);
         mis = 0;
         exp_update = racc;
         if (racc) begin
            e = mq[0];
            mis = (e.take != rben) || (e.take && rben && (e.tgt != rtg));
            exp_upd_br_en = rben;
            exp_upd_waddr = e.pc;
         end
         exp_redirect = mis;
         if (mis) begin
            exp_redirect_pc = rben ? rtg : e.pc + 32'd4;
            mq.delete();
         end else begin
            if (racc) void'(mq.pop_front());
            if (p && (!was_full || racc)) mq.push_back('{pc: ppc, take: ptk, tgt: ptg});
         end
      end
      #1;
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_push(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
      step(0, 1, pc, tk, tg, 0, 0, 0);
   endtask

   task automatic test_reset();
      step(1, 1, 32'h10, 1, 32'h20, 1, 1, 32'h20);
      vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", count); end
      vectors++; if (empty !== 1'b1 || full !== 1'b0) begin miscompares++; $display("FAIL reset_flags: got empty=%b full=%b want 1 0", empty, full); end
      vectors++; if (update !== 1'b0 || upd_br_en !== 1'b0 || upd_waddr !== 32'h0) begin miscompares++; $display("FAIL reset_update: got %b %b %h want 0 0 0", update, upd_br_en, upd_waddr); end
      vectors++; if (redirect !== 1'b0 || redirect_pc !== 32'h0) begin miscompares++; $display("FAIL reset_redirect: got %b %h want 0 0", redirect, redirect_pc); end
   endtask

   task automatic test_correct_taken();
      step(1, 0, 0, 0, 0, 0, 0, 0);
      do_push(32'h100, 1, 32'h200);
      vectors++; if (count !== 4'd1) begin miscompares++; $display("FAIL ct_count1: got %0d want 1", count); end
      step(0, 0, 0, 0, 0, 1, 1, 32'h200);
      vectors++; if (update !== 1'b1 || upd_waddr !== 32'h100 || upd_br_en !== 1'b1) begin miscompares++; $display("FAIL ct_update: got %b %h %b want 1 00000100 1", update, upd_waddr, upd_br_en); end
      vectors++; if (redirect !== 1'b0 || empty !== 1'b1) begin miscompares++; $display("FAIL ct_redir_empty: got %b %b want 0 1", redirect, empty); end
      idle();
      vectors++; if (update !== 1'b0) begin miscompares++; $display("FAIL ct_update_pulse: got %b want 0", update); end
   endtask

   task automatic test_not_taken_mispredict();
      step(1, 0, 0, 0, 0, 0, 0, 0);
      do_push(32'h40, 1, 32'h80);
      step(0, 0, 0, 0, 0, 1, 0, 32'h0);
      vectors++; if (redirect !== 1'b1 || redirect_pc !== 32'h44) begin miscompares++; $display("FAIL nt_redirect: got %b %h want 1 00000044", redirect, redirect_pc); end
      vectors++; if (update !== 1'b1 || upd_br_en !== 1'b0) begin miscompares++; $display("FAIL nt_update: got %b %b want 1 0", update, upd_br_en); end
      vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL nt_count: got %0d want 0", count); end
      idle();
      vectors++; if (redirect !== 1'b0 || update !== 1'b0) begin miscompares++; $display("FAIL nt_pulse: got %b %b want 0 0", redirect, update); end
   endtask

   task automatic test_full();
      logic [31:0] want;
      step(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) do_push(32'h1000 + 32'(4 * i), 0, 0);
      vectors++; if (full !== 1'b1 || count !== 4'd8) begin miscompares++; $display("FAIL full_set: got full=%b count=%0d want 1 8", full, count); end
      do_push(32'h1ff0, 0, 0);
      vectors++; if (count !== 4'd8) begin miscompares++; $display("FAIL full_drop: got %0d want 8", count); end
      step(0, 1, 32'h2000, 0, 0, 1, 0, 0);
      vectors++; if (count !== 4'd8 || upd_waddr !== 32'h1000 || redirect !== 1'b0) begin miscompares++; $display("FAIL full_pushres: got count=%0d waddr=%h redir=%b want 8 00001000 0", count, upd_waddr, redirect); end
      for (int i = 0; i < 8; i++) begin
         want = (i < 7) ? 32'h1004 + 32'(4 * i) : 32'h2000;
         step(0, 0, 0, 0, 0, 1, 0, 0);
         vectors++; if (update !== 1'b1 || upd_waddr !== want) begin miscompares++; $display("FAIL full_drain%0d: got %b %h want 1 %h", i, update, upd_waddr, want); end
      end
      vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL full_empty: got %b want 1", empty); end
   endtask

   task automatic test_target_mismatch();
      step(1, 0, 0, 0, 0, 0, 0, 0);
      do_push(32'h500, 1, 32'h300);
      do_push(32'h504, 0, 0);
      do_push(32'h508, 1, 32'h600);
      step(0, 1, 32'h50c, 0, 0, 1, 1, 32'h304);
      vectors++; if (redirect !== 1'b1 || redirect_pc !== 32'h304) begin miscompares++; $display("FAIL tm_redirect: got %b %h want 1 00000304", redirect, redirect_pc); end
      vectors++; if (empty !== 1'b1 || count !== 4'd0) begin miscompares++; $display("FAIL tm_empty: got %b %0d want 1 0", empty, count); end
      step(0, 0, 0, 0, 0, 1, 0, 0);
      vectors++; if (update !== 1'b0 || redirect !== 1'b0) begin miscompares++; $display("FAIL tm_discard: got %b %b want 0 0", update, redirect); end
   endtask

   task automatic test_empty_and_reset();
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 1, 32'h44);
      vectors++; if (update !== 1'b0 || redirect !== 1'b0) begin miscompares++; $display("FAIL er_empty_res: got %b %b want 0 0", update, redirect); end
      do_push(32'h700, 0, 0);
      step(1, 1, 32'h704, 0, 0, 1, 1, 32'h9);
      vectors++; if (count !== 4'd0 || update !== 1'b0 || redirect !== 1'b0 || upd_waddr !== 32'h0 || redirect_pc !== 32'h0 || upd_br_en !== 1'b0) begin
         miscompares++; $display("FAIL er_rst_prio: got count=%0d upd=%b red=%b waddr=%h rpc=%h ben=%b want all 0", count, update, redirect, upd_waddr, redirect_pc, upd_br_en); end
      idle();
      vectors++; if (update !== 1'b0 || redirect !== 1'b0 || empty !== 1'b1) begin miscompares++; $display("FAIL er_after_rst: got %b %b %b want 0 0 1", update, redirect, empty); end
   endtask

`ifdef BRQ_STATS_EN
   task automatic test_stats();
      step(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         do_push(32'h800 + 32'(16 * i), 1, 32'h900);
         step(0, 0, 0, 0, 0, 1, 1, (i == 1 || i == 3) ? 32'h904 : 32'h900);
      end
      idle(); idle();
      vectors++; if (stat_resolved !== 32'd5) begin miscompares++; $display("FAIL stats_resolved: got %0d want 5", stat_resolved); end
      vectors++; if (stat_mispred !== 32'd2) begin miscompares++; $display("FAIL stats_mispred: got %0d want 2", stat_mispred); end
   endtask
`endif

   task automatic test_random();
      logic        r, p, tk, rs, ben;
      logic [31:0] pc, tg, rtg;
      step(1, 0, 0, 0, 0, 0, 0, 0);
      for (int n = 0; n < 400; n++) begin
         r   = ($urandom_range(0, 49) == 0);
         p   = ($urandom_range(0, 9) < 7);
         rs  = ($urandom_range(0, 9) < 4);
         tk  = 1'($urandom);
         ben = ($urandom_range(0, 3) != 0) ? tk : ~tk;
         pc  = {$urandom} & 32'hfffc;
         if ($urandom_range(0, 19) == 0) pc = 32'hfffffffc;
         tg  = ($urandom_range(0, 1) == 1) ? 32'h300 : 32'h304;
         rtg = ($urandom_range(0, 3) == 0) ? 32'h304 : 32'h300;
         step(r, p, pc, tk, tg, rs, ben, rtg);
         vectors++;
         if (count !== 4'(mq.size()) || empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH)) begin
            miscompares++; $display("FAIL rnd_occ@%0d: got count=%0d e=%b f=%b want %0d", n, count, empty, full, mq.size()); end
         vectors++;
         if (update !== exp_update || (exp_update && (upd_br_en !== exp_upd_br_en || upd_waddr !== exp_upd_waddr))) begin
            miscompares++; $display("FAIL rnd_update@%0d: got %b %b %h want %b %b %h", n, update, upd_br_en, upd_waddr, exp_update, exp_upd_br_en, exp_upd_waddr); end
         vectors++;
         if (redirect !== exp_redirect || (exp_redirect && redirect_pc !== exp_redirect_pc)) begin
            miscompares++; $display("FAIL rnd_redirect@%0d: got %b %h want %b %h", n, redirect, redirect_pc, exp_redirect, exp_redirect_pc); end
`ifdef BRQ_STATS_EN
         vectors++;
         if (stat_resolved !== exp_res || stat_mispred !== exp_mis) begin
            miscompares++; $display("FAIL rnd_stats@%0d: got %0d %0d want %0d %0d", n, stat_resolved, stat_mispred, exp_res, exp_mis); end
`endif
      end
   endtask

   initial begin
      rst = 1; push = 0; push_pc = 0; push_take = 0; push_target = 0;
      resolve = 0; resolve_br_en = 0; resolve_target = 0;
      test_reset();
      test_correct_taken();
      test_not_taken_mispredict();
      test_full();
      test_target_mismatch();
      test_empty_and_reset();
`ifdef BRQ_STATS_EN
      test_stats();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/br_resolve_queue.md
BR_RESOLVE_QUEUE -- requirements
Module: br_resolve_queue

Interface
REQ-001 SHALL have parameter s_idx, default 3, meaning log2 of queue depth (depth = 2**s_idx entries).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port push  input  1  fetch records one predicted branch.
REQ-005 SHALL have port push_pc  input  32  PC of the pushed branch.
REQ-006 SHALL have port push_take  input  1  predicted direction from the predictor's br_take.
REQ-007 SHALL have port push_target  input  32  predicted target, meaningful only when push_take=1.
REQ-008 SHALL have port resolve  input  1  execute resolves the oldest entry.
REQ-009 SHALL have port resolve_br_en  input  1  actual branch outcome.
REQ-010 SHALL have port resolve_target  input  32  actual taken target.
REQ-011 SHALL have port full  output  1  count == depth.
REQ-012 SHALL have port empty  output  1  count == 0.
REQ-013 SHALL have port count  output  s_idx+1  current occupancy.
REQ-014 SHALL have port update  output  1  predictor-table write strobe.
REQ-015 SHALL have port upd_br_en  output  1  outcome for the predictor write.
REQ-016 SHALL have port upd_waddr  output  32  PC for the predictor write.
REQ-017 SHALL have port redirect  output  1  mispredict; fetch redirect and pipeline flush.
REQ-018 SHALL have port redirect_pc  output  32  correct next PC.

Function
REQ-019 SHALL hold entries {pc, take, target} in a circular FIFO with s_idx-bit head/tail pointers that wrap modulo depth.
REQ-020 SHALL accept a push when push=1 and either full=0, or resolve=1 is accepted in the same cycle with no mispredict.
REQ-021 SHALL silently drop a push when full=1 and no resolve is accepted in that cycle.
REQ-022 SHALL accept a resolve only when empty=0; SHALL ignore a resolve when empty=1, with no update and no redirect.
REQ-023 SHALL flag a mispredict on an accepted resolve when take != resolve_br_en, or when take=resolve_br_en=1 and target != resolve_target.
REQ-024 SHALL, for an accepted resolve in cycle N, assert update for exactly cycle N+1, with upd_br_en=resolve_br_en and upd_waddr=entry pc, all from registers.
REQ-025 SHALL, on a mispredict in cycle N, assert redirect for exactly cycle N+1, with redirect_pc=resolve_target if resolve_br_en=1, else entry pc+4 (32-bit wrap).
REQ-026 SHALL, on a mispredict in cycle N, empty the queue at the end of cycle N (head=tail, count=0) and discard any same-cycle push.
REQ-027 SHALL, when push and resolve are both accepted without a mispredict, leave count unchanged.
REQ-028 SHALL derive full, empty and count combinationally from the registered pointers and a registered count.
REQ-029 SHALL hold update=0 and redirect=0 in every cycle not covered by REQ-024 or REQ-025.

Reset
REQ-030 SHALL, while rst=1 at a rising edge: set head=tail=0, count=0, update=0, upd_br_en=0, upd_waddr=0, redirect=0, redirect_pc=0.
REQ-031 SHALL give rst priority over a same-cycle push or resolve; neither takes effect, and no update or redirect follows.
REQ-032 SHALL NOT require entry storage to be reset.

Configuration
REQ-033 SHALL, with macro BRQ_STATS_EN defined, add outputs stat_resolved (32) and stat_mispred (32): wrapping counters of accepted resolves and mispredicts, incremented in cycle N+1, cleared by rst.
REQ-034 SHALL, without BRQ_STATS_EN, omit those ports and counters; all other behaviour is identical.

Verification
REQ-035 SHALL cover: after reset, push pc=0x100 take=1 target=0x200, then resolve br_en=1 target=0x200 -> one-cycle update with upd_waddr=0x100, upd_br_en=1; redirect=0; empty=1.
REQ-036 SHALL cover: push pc=0x40 take=1 target=0x80, then resolve br_en=0 -> redirect=1 with redirect_pc=0x44, update=1 with upd_br_en=0, count=0 next cycle.
REQ-037 SHALL cover: push 8 entries (s_idx=3) -> full=1; 9th push alone dropped; push+resolve (correct) in the same cycle -> count stays 8; 8 drains return the PCs in FIFO order.
REQ-038 SHALL cover: 3 entries queued, resolve the oldest with a target mismatch (pred 0x300, actual 0x304) while pushing -> redirect_pc=0x304, queue empty, push discarded.
REQ-039 SHALL cover: resolve with empty=1 -> no update, no redirect; rst asserted with push+resolve pending -> count=0, all outputs 0 next cycle.
REQ-040 SHALL cover, with BRQ_STATS_EN: 5 resolves including 2 mispredicts -> stat_resolved=5, stat_mispred=2.
